// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: round-robin grant, one registered memory access cycle,
// then a one-cycle response strobe to the granted port.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [1:0]        p0_size,
    input  logic              p0_unsign,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic [1:0]        p1_size,
    input  logic              p1_unsign,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic              st_byte,
    output logic              st_hw,
    output logic              ld_byte,
    output logic              ld_hw,
    output logic              unsign,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]        state, state_nxt;
    logic              ptr;
    logic              cmd_we, cmd_unsign, cmd_port;
    logic [1:0]        cmd_size;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err, resp_port;
    logic              can_grant, any_gnt, misaligned, in_access, go;

    // Gated by reset so no grant escapes while the block is held in reset.
    assign can_grant = reset && (state != ACCESS);
    assign p0_gnt    = can_grant && p0_req && (!p1_req || !ptr);
    assign p1_gnt    = can_grant && p1_req && (!p0_req || ptr);
    assign any_gnt   = p0_gnt || p1_gnt;

    always_comb begin
        misaligned = 1'b0;
        if (cmd_size == 2'b01)
            misaligned = cmd_addr[0];
        else if (cmd_size[1])
            misaligned = |cmd_addr[1:0];
    end

    assign in_access = (state == ACCESS);
    assign go        = in_access && !misaligned;
    assign mem_read  = go && !cmd_we;
    assign mem_write = go && cmd_we;
    assign st_byte   = go && cmd_we && (cmd_size == 2'b00);
    assign st_hw     = go && cmd_we && (cmd_size == 2'b01);
    assign ld_byte   = go && !cmd_we && (cmd_size == 2'b00);
    assign ld_hw     = go && !cmd_we && (cmd_size == 2'b01);
    assign unsign    = in_access && cmd_unsign;
    assign mem_addr  = cmd_addr;
    assign mem_wdata = cmd_wdata;

    assign p0_rvalid = (state == RESP) && !resp_port;
    assign p1_rvalid = (state == RESP) && resp_port;
    assign p0_rdata  = p0_rvalid ? resp_data : '0;
    assign p1_rdata  = p1_rvalid ? resp_data : '0;
    assign p0_err    = p0_rvalid && resp_err;
    assign p1_err    = p1_rvalid && resp_err;

    always_comb begin
        state_nxt = IDLE;
        case (state)
            ACCESS:  state_nxt = RESP;
            default: state_nxt = any_gnt ? ACCESS : IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ptr        <= 1'b0;
            cmd_we     <= 1'b0;
            cmd_unsign <= 1'b0;
            cmd_port   <= 1'b0;
            cmd_size   <= 2'b00;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            resp_port  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (any_gnt) begin
                ptr        <= p0_gnt;
                cmd_port   <= p1_gnt;
                cmd_we     <= p1_gnt ? p1_we     : p0_we;
                cmd_unsign <= p1_gnt ? p1_unsign : p0_unsign;
                cmd_size   <= p1_gnt ? p1_size   : p0_size;
                cmd_addr   <= p1_gnt ? p1_addr   : p0_addr;
                cmd_wdata  <= p1_gnt ? p1_wdata  : p0_wdata;
            end
            // Stores and faulting accesses return zero data.
            if (in_access) begin
                resp_data <= mem_read ? mem_rdata : '0;
                resp_err  <= misaligned;
                resp_port <= cmd_port;
            end
        end
    end

endmodule
